// File: rtl/match_scheduler.sv
// match_scheduler: captures one block of live samples, replays it to a bank of
// matched filters for every sum/phase/similarity pass, then collects the
// per-filter scores and reports the lowest-scoring (best-matching) filter.
module match_scheduler #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int MATCH_SCORE_WIDTH = 32,
  parameter int CAPTURE_LENGTH    = 1000,
  parameter int NUM_FILTERS       = 4,
  parameter int GAP_CYCLES        = 4,
  parameter int TIMEOUT_CYCLES    = 1024,
  localparam int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0]             axiid,
  output logic                                     filt_rst,
  output logic                                     filt_axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0]             filt_axiod,
  input  logic [NUM_FILTERS-1:0]                   score_valid,
  input  logic [NUM_FILTERS*MATCH_SCORE_WIDTH-1:0] score,
  output logic                                     busy,
  output logic                                     done,
  output logic [IDX_W-1:0]                         best_index,
  output logic [MATCH_SCORE_WIDTH-1:0]             best_score,
  output logic                                     score_error
);

  localparam int ADDR_W     = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1;
  localparam int NUM_PASSES = 2 * CAPTURE_LENGTH + 2;
  localparam int PASS_W     = $clog2(NUM_PASSES + 1);
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, REPLAY, GAP, COLLECT, SELECT, DONE} state_t;

  state_t                          state_reg, state_next;
  logic [ADDR_W-1:0]               wr_addr_reg, rd_addr_reg;
  logic                            cap_full_reg;
  logic [PASS_W-1:0]               pass_cnt_reg;
  logic [GAP_W-1:0]                gap_cnt_reg;
  logic [TMO_W-1:0]                tmo_cnt_reg;
  logic                            err_flag_reg;
  logic [SAMPLE_DATA_WIDTH-1:0]    mem [CAPTURE_LENGTH];
  logic [SAMPLE_DATA_WIDTH-1:0]    mem_q_reg, axiod_reg;
  logic                            v1_reg, v2_reg;
  logic [NUM_FILTERS-1:0]          got_vec;
  logic [MATCH_SCORE_WIDTH-1:0]    lat_arr [NUM_FILTERS];
  logic [IDX_W-1:0]                sel_idx_reg, cand_idx_reg, cand_idx_next;
  logic [MATCH_SCORE_WIDTH-1:0]    cand_score_reg, cand_score_next;
  logic                            cand_valid_reg, cand_valid_next, take;

  logic start_accept, wr_en, rd_last, gap_last, tmo_last, scan_last, lat_en;

  assign start_accept = (state_reg == IDLE) && start;
  assign wr_en        = (state_reg == CAPTURE) && axiiv && !cap_full_reg;
  assign rd_last      = (rd_addr_reg == ADDR_W'(CAPTURE_LENGTH - 1));
  assign gap_last     = (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1));
  assign tmo_last     = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
  assign scan_last    = (sel_idx_reg == IDX_W'(NUM_FILTERS - 1));
  assign lat_en       = (state_reg == REPLAY) || (state_reg == GAP) || (state_reg == COLLECT);
  assign filt_axiov   = v2_reg;
  assign filt_axiod   = axiod_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decode and state-derived outputs; filters stay in reset
  // outside the replay/collect/select window.
  always_comb begin
    state_next = state_reg;
    filt_rst   = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = CAPTURE;
      end
      CAPTURE: if (cap_full_reg) state_next = REPLAY;
      REPLAY: begin
        filt_rst = 1'b0;
        if (rd_last) state_next = GAP;
      end
      GAP: begin
        filt_rst = 1'b0;
        if (gap_last) state_next = (pass_cnt_reg < PASS_W'(NUM_PASSES)) ? REPLAY : COLLECT;
      end
      COLLECT: begin
        filt_rst = 1'b0;
        if ((&got_vec) || tmo_last) state_next = SELECT;
      end
      SELECT: begin
        filt_rst = 1'b0;
        if (scan_last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture/replay addressing, pass, gap and timeout counters, error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_reg  <= '0;
      cap_full_reg <= 1'b0;
      rd_addr_reg  <= '0;
      pass_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      tmo_cnt_reg  <= '0;
      err_flag_reg <= 1'b0;
    end else begin
      if (start_accept) begin
        wr_addr_reg  <= '0;
        cap_full_reg <= 1'b0;
        pass_cnt_reg <= '0;
        err_flag_reg <= 1'b0;
      end
      if (wr_en) begin
        wr_addr_reg <= wr_addr_reg + 1'b1;
        if (wr_addr_reg == ADDR_W'(CAPTURE_LENGTH - 1)) cap_full_reg <= 1'b1;
      end
      // No wrap: every pass restarts reading from address 0.
      if (state_reg == REPLAY) begin
        rd_addr_reg <= rd_last ? '0 : rd_addr_reg + 1'b1;
        if (rd_last) pass_cnt_reg <= pass_cnt_reg + 1'b1;
      end else begin
        rd_addr_reg <= '0;
      end
      gap_cnt_reg <= ((state_reg == GAP) && !gap_last) ? gap_cnt_reg + 1'b1 : '0;
      tmo_cnt_reg <= (state_reg == COLLECT) ? tmo_cnt_reg + 1'b1 : '0;
      if ((state_reg == COLLECT) && tmo_last && !(&got_vec)) err_flag_reg <= 1'b1;
    end
  end

  // Capture buffer: single write port, registered read (first latency stage).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_reg] <= axiid;
    mem_q_reg <= mem[rd_addr_reg];
  end

  // Second read stage plus valid pipeline; data holds while no sample is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      axiod_reg <= '0;
    end else begin
      v1_reg <= (state_reg == REPLAY);
      v2_reg <= v1_reg;
      if (v1_reg) axiod_reg <= mem_q_reg;
    end
  end

  // Per-filter score latches; later strobes from the same filter overwrite.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FILTERS; gi++) begin : g_lat
      logic                         got_bit_reg;
      logic [MATCH_SCORE_WIDTH-1:0] lat_reg;
      // Latch this filter's score while the bank is running.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          got_bit_reg <= 1'b0;
          lat_reg     <= '0;
        end else if (start_accept) begin
          got_bit_reg <= 1'b0;
        end else if (lat_en && score_valid[gi]) begin
          got_bit_reg <= 1'b1;
          lat_reg     <= score[gi*MATCH_SCORE_WIDTH +: MATCH_SCORE_WIDTH];
        end
      end
      assign got_vec[gi] = got_bit_reg;
      assign lat_arr[gi] = lat_reg;
    end
  endgenerate

  // Candidate update for the filter under scan: strict less-than keeps the lower index on ties.
  always_comb begin
    take            = (state_reg == SELECT) && got_vec[sel_idx_reg] &&
                      (!cand_valid_reg || (lat_arr[sel_idx_reg] < cand_score_reg));
    cand_valid_next = cand_valid_reg | take;
    cand_idx_next   = take ? sel_idx_reg : cand_idx_reg;
    cand_score_next = take ? lat_arr[sel_idx_reg] : cand_score_reg;
  end

  // Sequential scan, one filter per cycle; results publish as DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_idx_reg    <= '0;
      cand_valid_reg <= 1'b0;
      cand_idx_reg   <= '0;
      cand_score_reg <= '1;
      best_index     <= '0;
      best_score     <= '0;
      score_error    <= 1'b0;
    end else if (state_reg == COLLECT) begin
      sel_idx_reg    <= '0;
      cand_valid_reg <= 1'b0;
      cand_idx_reg   <= '0;
      cand_score_reg <= '1;
    end else if (state_reg == SELECT) begin
      sel_idx_reg    <= sel_idx_reg + 1'b1;
      cand_valid_reg <= cand_valid_next;
      cand_idx_reg   <= cand_idx_next;
      cand_score_reg <= cand_score_next;
      if (scan_last) begin
        best_index  <= cand_valid_next ? cand_idx_next : '0;
        best_score  <= cand_valid_next ? cand_score_next : '1;
        score_error <= err_flag_reg | !cand_valid_next;
      end
    end
  end

endmodule

// File: tb/tb_match_scheduler.sv
// Directed bench for match_scheduler with a short capture (L=8) and short timeout.
module tb_match_scheduler;
  localparam int D   = 8;
  localparam int W   = 32;
  localparam int L   = 8;
  localparam int N   = 4;
  localparam int G   = 4;
  localparam int TMO = 64;
  localparam int NP  = 2 * L + 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           axiiv = 1'b0;
  logic [D-1:0]   axiid = '0;
  logic           filt_rst, filt_axiov;
  logic [D-1:0]   filt_axiod;
  logic [N-1:0]   score_valid = '0;
  logic [N*W-1:0] score = '0;
  logic           busy, done, score_error;
  logic [1:0]     best_index;
  logic [W-1:0]   best_score;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  match_scheduler #(
    .SAMPLE_DATA_WIDTH(D), .MATCH_SCORE_WIDTH(W), .CAPTURE_LENGTH(L),
    .NUM_FILTERS(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .axiiv(axiiv), .axiid(axiid),
    .filt_rst(filt_rst), .filt_axiov(filt_axiov), .filt_axiod(filt_axiod),
    .score_valid(score_valid), .score(score), .busy(busy), .done(done),
    .best_index(best_index), .best_score(best_score), .score_error(score_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full run: start, capture, replay monitoring, score strobes, result check.
  // smode: 0 nominal sequential, 1 tie simultaneous, 2 filters 2/3 only, 3 none.
  task automatic do_run(input string name, input bit bursty, input bit start_gap,
                        input bit rst_mid, input int smode, input logic [D-1:0] base,
                        input int exp_idx, input logic [W-1:0] exp_score, input bit exp_err);
    logic [D-1:0] exp_d [L];
    int nom [N];
    int last_edge, first_c, last_c, vcnt, runlen, gaplen, passes;
    int data_err, gap_err, len_err, hold_err, frst_err, dcnt, post;
    bit seen, did_start;
    logic [D-1:0] last_d;
    logic [1:0]   r_idx;
    logic [W-1:0] r_score;
    logic         r_err;
    nom = '{50, 20, 90, 70};
    first_c = 0; last_c = 0; vcnt = 0; runlen = 0; gaplen = 0; passes = 0;
    data_err = 0; gap_err = 0; len_err = 0; hold_err = 0; frst_err = 0;
    dcnt = 0; post = 0; seen = 0; did_start = 0; last_d = '0;
    r_idx = 'x; r_score = 'x; r_err = 1'bx;
    for (int i = 0; i < L; i++) exp_d[i] = base + 8'(i);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val({name, ".busy_after_start"}, busy, 1);
    for (int i = 0; i < L; i++) begin
      axiiv = 1'b1; axiid = exp_d[i];
      @(negedge clk);
      if (i == 0) check_val({name, ".filt_rst_capture"}, filt_rst, 1);
      if (bursty && i < L - 1) begin
        axiiv = 1'b0; axiid = 8'hEE;
        @(negedge clk);
      end
    end
    last_edge = cyc;
    axiiv = 1'b0; axiid = '0;

    for (int t = 0; t < 600 && vcnt < NP * L; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (filt_axiov) begin
        if (!seen) first_c = cyc;
        else if (gaplen > 0 && gaplen != G) gap_err++;
        seen = 1; gaplen = 0;
        if (runlen < L) begin
          if (filt_axiod !== exp_d[runlen]) data_err++;
        end
        runlen++; vcnt++; last_c = cyc; last_d = filt_axiod;
        if (filt_rst) frst_err++;
        if (rst_mid && passes == 4 && runlen == 3) begin
          rst_n = 1'b0;
          #1;
          check_val({name, ".rst_axiov"}, filt_axiov, 0);
          check_val({name, ".rst_filt_rst"}, filt_rst, 1);
          check_val({name, ".rst_busy"}, busy, 0);
          check_val({name, ".rst_best_score"}, best_score, 0);
          $display("[TB] run %s: async reset during pass %0d, busy=%0b filt_axiov=%0b", name, passes + 1, busy, filt_axiov);
          @(negedge clk); @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end else if (seen) begin
        if (runlen > 0) begin
          if (runlen != L) len_err++;
          passes++; runlen = 0;
          if (start_gap && passes == 3 && !did_start) begin
            start = 1'b1; did_start = 1;
          end
        end
        gaplen++;
        if (filt_axiod !== last_d) hold_err++;
      end
    end
    start = 1'b0;
    if (runlen > 0) begin
      if (runlen != L) len_err++;
      passes++;
    end
    check_val({name, ".first_valid_latency"}, first_c - last_edge, 3);
    check_val({name, ".passes"}, passes, NP);
    check_val({name, ".replay_span"}, last_c - first_c + 1, NP * (L + G) - G);
    check_val({name, ".gap_errors"}, gap_err, 0);
    check_val({name, ".len_errors"}, len_err, 0);
    check_val({name, ".data_errors"}, data_err, 0);
    check_val({name, ".hold_errors"}, hold_err, 0);
    check_val({name, ".filt_rst_errors"}, frst_err, 0);

    repeat (4) @(negedge clk);
    score = '0;
    case (smode)
      0: for (int i = 0; i < N; i++) begin
           score_valid = 4'(1 << i);
           score[i*W +: W] = 32'(nom[i]);
           @(negedge clk);
         end
      1: begin
           score = {32'd30, 32'd40, 32'd30, 32'd30};
           score_valid = 4'hF;
           @(negedge clk);
         end
      2: begin
           score[2*W +: W] = 32'd15;
           score[3*W +: W] = 32'd9;
           score_valid = 4'b1100;
           @(negedge clk);
         end
      default: ;
    endcase
    score_valid = '0;

    for (int t = 0; t < TMO + 100 && post < 6; t++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (dcnt == 1) begin
          r_idx = best_index; r_score = best_score; r_err = score_error;
        end
      end
      if (dcnt > 0) post++;
    end
    check_val({name, ".done_count"}, dcnt, 1);
    check_val({name, ".best_index"}, r_idx, exp_idx);
    check_val({name, ".best_score"}, r_score, exp_score);
    check_val({name, ".score_error"}, r_err, exp_err);
    check_val({name, ".busy_after_done"}, busy, 0);
    check_val({name, ".hold_best_score"}, best_score, exp_score);
    check_val({name, ".hold_score_error"}, score_error, exp_err);
    $display("[TB] run %s: passes=%0d span=%0d dones=%0d best_index=%0d best_score=0x%0h score_error=%0b",
             name, passes, last_c - first_c + 1, dcnt, r_idx, r_score, r_err);
  endtask

  initial begin
    #1;
    check_val("reset.filt_rst", filt_rst, 1);
    check_val("reset.filt_axiov", filt_axiov, 0);
    check_val("reset.filt_axiod", filt_axiod, 0);
    check_val("reset.busy", busy, 0);
    check_val("reset.done", done, 0);
    check_val("reset.best_index", best_index, 0);
    check_val("reset.best_score", best_score, 0);
    check_val("reset.score_error", score_error, 0);
    $display("[TB] reset: busy=%0b filt_rst=%0b best_score=0x%0h", busy, filt_rst, best_score);
    #20;
    @(negedge clk); rst_n = 1'b1;

    do_run("nominal",          0, 0, 0, 0, 8'h00, 1, 32'd20,        0);
    do_run("bursty_tie_start", 1, 1, 0, 1, 8'hA0, 0, 32'd30,        0);
    do_run("timeout_2_3",      0, 0, 0, 2, 8'h10, 3, 32'd9,         1);
    do_run("timeout_none",     0, 0, 0, 3, 8'h20, 0, 32'hFFFFFFFF,  1);
    do_run("reset_mid",        0, 0, 1, 0, 8'h30, 0, 32'd0,         0);
    do_run("after_reset",      0, 0, 0, 0, 8'h40, 1, 32'd20,        0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
